// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into N-bit words, writes them to
// the instruction RAM from word address 0 and holds the core in reset until loading completes.
module imem_loader #(
  parameter int N     = 32,
  parameter int AW    = 6,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  input  logic          s_last,
  output logic          s_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [N-1:0]  wdata,
  output logic [AW:0]   words,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  localparam int NB = N / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] byteCnt_q, byteCnt_d;
  logic          lastSeen_q, lastSeen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [AW:0]   words_q, words_d;
  logic          err_q, err_d;
  logic          sReady_q, we_q, cpuHold_q, done_q;
  logic          accept;
  logic          wordFull;
  logic          ramFull;

  assign accept   = s_valid && sReady_q;
  assign wordFull = (byteCnt_q == BW'(NB - 1));
  assign ramFull  = (waddr_q == AW'(DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    byteCnt_d  = byteCnt_q;
    lastSeen_d = lastSeen_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    words_d    = words_q;
    err_d      = err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = LOAD;
          byteCnt_d  = '0;
          lastSeen_d = 1'b0;
          waddr_d    = '0;
          wdata_d    = '0;
          words_d    = '0;
          err_d      = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          // Clearing on the first byte zero-pads a word cut short by s_last.
          if (byteCnt_q == '0) wdata_d = '0;
          wdata_d[8*byteCnt_q +: 8] = s_data;
          if (wordFull || s_last) begin
            state_d    = WRITE;
            lastSeen_d = s_last;
            if (s_last && !wordFull) err_d = 1'b1;
          end else begin
            byteCnt_d = byteCnt_q + BW'(1);
          end
        end
      end
      WRITE: begin
        byteCnt_d = '0;
        words_d   = words_q + (AW+1)'(1);
        if (!ramFull) waddr_d = waddr_q + AW'(1);
        // A terminated image takes priority over the full-RAM overflow case.
        if (lastSeen_q) begin
          state_d = DONE;
        end else if (ramFull) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs are registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byteCnt_q  <= '0;
      lastSeen_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      words_q    <= '0;
      err_q      <= 1'b0;
      sReady_q   <= 1'b0;
      we_q       <= 1'b0;
      cpuHold_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byteCnt_q  <= byteCnt_d;
      lastSeen_q <= lastSeen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      words_q    <= words_d;
      err_q      <= err_d;
      sReady_q   <= (state_d == LOAD);
      we_q       <= (state_d == WRITE);
      cpuHold_q  <= (state_d != DONE);
      done_q     <= (state_d == DONE);
    end
  end

  assign s_ready  = sReady_q;
  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign words    = words_q;
  assign cpu_hold = cpuHold_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected RAM writes,
// a monitor pops and compares them whenever the loader asserts we.
module tb_imem_loader;

  localparam int N     = 32;
  localparam int AW    = 6;
  localparam int DEPTH = 64;
  localparam int NB    = N / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [N-1:0]  wdata;
  logic [AW:0]   words;
  logic          cpu_hold;
  logic          done;
  logic          err;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } wr_t;

  wr_t          expQ[$];
  wr_t          popped;
  byte unsigned imgBytes[$];
  int           imgLast;
  int           vectors = 0;
  int           miscompares = 0;
  int           expWords, expWaddr, expAccepted, acceptedCnt;
  bit           expErr;
  bit           gapsOn = 1'b1;
  bit           startNoise = 1'b0;

  imem_loader #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .words    (words),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic void checkOutput(string name, logic [63:0] actual, logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endfunction

  // Monitor: every write the loader issues must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && we) begin
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: got write 0x%0h@%0d, expected no write", wdata, waddr);
      end else begin
        popped = expQ.pop_front();
        checkOutput("waddr", 64'(waddr), 64'(popped.addr));
        checkOutput("wdata", 64'(wdata), 64'(popped.data));
        checkOutput("s_ready_during_write", 64'(s_ready), 64'd0);
      end
    end
  end

  function automatic void pushWrite(int addr, logic [N-1:0] data);
    wr_t w;
    w.addr = AW'(addr);
    w.data = data;
    expQ.push_back(w);
  endfunction

  function automatic void setExpect(int w, bit e, int wa, int acc);
    expWords    = w;
    expErr      = e;
    expWaddr    = wa;
    expAccepted = acc;
  endfunction

  // Reference model: chop the accepted prefix of the image into words of NB bytes.
  function automatic void buildExpected();
    int nbytes;
    int nw;
    bit overflow;
    logic [N-1:0] data;
    nbytes   = (imgLast >= 0) ? imgLast + 1 : imgBytes.size();
    overflow = 1'b0;
    if (imgLast < 0 || nbytes > DEPTH * NB) begin
      nbytes   = DEPTH * NB;
      overflow = 1'b1;
    end
    nw = (nbytes + NB - 1) / NB;
    for (int w = 0; w < nw; w++) begin
      data = '0;
      for (int b = 0; b < NB; b++)
        if (w * NB + b < nbytes) data[8*b +: 8] = imgBytes[w * NB + b];
      pushWrite(w, data);
    end
    setExpect(nw, overflow || (nbytes % NB != 0), (nw >= DEPTH) ? DEPTH - 1 : nw, nbytes);
  endfunction

  task automatic doStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_cpu_hold", 64'(cpu_hold), 64'd1);
    checkOutput("start_done", 64'(done), 64'd0);
    checkOutput("start_s_ready", 64'(s_ready), 64'd1);
    checkOutput("start_words", 64'(words), 64'd0);
    checkOutput("start_err", 64'(err), 64'd0);
  endtask

  task automatic applyStimulus();
    int i = 0;
    int guard = 0;
    int limit = 20 * imgBytes.size() + 100;
    acceptedCnt = 0;
    while (i < imgBytes.size() && guard < limit) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (done) break;
      start = startNoise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (gapsOn && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        s_last  = 1'($urandom_range(0, 1));
      end else begin
        s_valid = 1'b1;
        s_data  = imgBytes[i];
        s_last  = (i == imgLast);
        if (s_ready) begin
          i++;
          acceptedCnt++;
        end
      end
    end
    if (guard >= limit) checkOutput("stream_timeout", 64'(guard), 64'(limit - 1));
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic waitDone(string tag);
    int cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
    checkOutput({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    checkOutput({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    checkOutput({tag, "_words"}, 64'(words), 64'(expWords));
    checkOutput({tag, "_err"}, 64'(err), 64'(expErr));
    checkOutput({tag, "_waddr"}, 64'(waddr), 64'(expWaddr));
    checkOutput({tag, "_accepted"}, 64'(acceptedCnt), 64'(expAccepted));
    checkOutput({tag, "_pending_writes"}, 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  initial begin
    int cnt;
    int guard;
    int len;
    reset   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
    checkOutput("rst_we", 64'(we), 64'd0);
    checkOutput("rst_waddr", 64'(waddr), 64'd0);
    checkOutput("rst_wdata", 64'(wdata), 64'd0);
    checkOutput("rst_words", 64'(words), 64'd0);
    checkOutput("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    reset = 1'b1;

    $display("[TB] single word image");
    doStart();
    imgBytes = '{8'h01, 8'h00, 8'h00, 8'hf8};
    imgLast  = 3;
    pushWrite(0, 32'hf8000001);
    setExpect(1, 1'b0, 1, 4);
    applyStimulus();
    waitDone("t1");

    $display("[TB] two words back to back");
    gapsOn = 1'b0;
    doStart();
    imgBytes = '{8'h01, 8'h00, 8'h00, 8'hf8, 8'h02, 8'h80, 8'h00, 8'hf8};
    imgLast  = 7;
    pushWrite(0, 32'hf8000001);
    pushWrite(1, 32'hf8008002);
    setExpect(2, 1'b0, 2, 8);
    applyStimulus();
    waitDone("t2");
    gapsOn = 1'b1;

    $display("[TB] short final word");
    doStart();
    imgBytes = '{8'h83, 8'h00, 8'h05};
    imgLast  = 2;
    pushWrite(0, 32'h00050083);
    setExpect(1, 1'b1, 1, 3);
    applyStimulus();
    waitDone("t3");

    $display("[TB] overflow with 65 words");
    doStart();
    imgBytes.delete();
    for (int k = 0; k < (DEPTH + 1) * NB; k++) imgBytes.push_back(8'($urandom));
    imgLast = -1;
    buildExpected();
    applyStimulus();
    waitDone("t4");

    $display("[TB] reset during partial word");
    doStart();
    cnt   = 0;
    guard = 0;
    while (cnt < 2 && guard < 50) begin
      @(negedge clk);
      guard++;
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      s_last  = 1'b0;
      if (s_ready) cnt++;
    end
    checkOutput("t5_partial_bytes", 64'(cnt), 64'd2);
    @(negedge clk);
    reset   = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("t5_cpu_hold", 64'(cpu_hold), 64'd1);
    checkOutput("t5_we", 64'(we), 64'd0);
    checkOutput("t5_waddr", 64'(waddr), 64'd0);
    checkOutput("t5_words", 64'(words), 64'd0);
    checkOutput("t5_s_ready", 64'(s_ready), 64'd0);
    reset = 1'b1;
    doStart();
    imgBytes.delete();
    for (int k = 0; k < NB; k++) imgBytes.push_back(8'($urandom));
    imgLast = NB - 1;
    buildExpected();
    applyStimulus();
    waitDone("t5");

    $display("[TB] restart from DONE with start noise during load");
    startNoise = 1'b1;
    doStart();
    imgBytes.delete();
    for (int k = 0; k < NB; k++) imgBytes.push_back(8'($urandom));
    imgLast = NB - 1;
    buildExpected();
    applyStimulus();
    waitDone("t6");

    $display("[TB] random images");
    for (int r = 0; r < 8; r++) begin
      gapsOn     = 1'($urandom_range(0, 1));
      startNoise = 1'($urandom_range(0, 1));
      len        = $urandom_range(1, 40);
      doStart();
      imgBytes.delete();
      for (int k = 0; k < len; k++) imgBytes.push_back(8'($urandom));
      imgLast = len - 1;
      buildExpected();
      applyStimulus();
      waitDone("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
